// File: rtl/pkt_rx_credit_proc.sv
// pkt_rx_credit_proc
//   Receive-side buffer for a credit-based link. Incoming beats are checked
//   for parity, optionally dropped when bad, and queued in a DEPTH-entry FIFO.
//   One credit is returned upstream for every buffer slot freed, either by a
//   downstream pop or by a dropped bad beat. At most one credit goes out per
//   cycle.
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   rx_valid    upstream beat valid (the sender holds a credit)
//   rx_data     upstream payload, DATA_W bits
//   rx_par      upstream parity bit
//   credit      one-cycle pulse that returns one credit upstream
//   out_valid   the buffer holds at least one beat
//   out_ready   downstream accepts the head beat
//   out_data    head-of-buffer payload (don't-care while out_valid=0)
//   err         one-cycle pulse, one cycle after a parity failure
//   err_cnt     saturating count of parity failures
//   ovf         sticky flag: a beat arrived while the buffer was full
//   clr         clears err_cnt and ovf

module pkt_rx_credit_proc #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 8,
  parameter int DROP_ERR = 1,
  parameter int ODD_PAR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_par,
  output logic              credit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err,
  output logic [15:0]       err_cnt,
  output logic              ovf,
  input  logic              clr
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  // Room for the pending count plus two increments in the same cycle.
  localparam int PEND_W = $clog2(DEPTH + 3);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(DEPTH);

  // Parity failure over {data, parity}; the expected reduction is ODD_PAR.
  function automatic logic par_fail(input logic [DATA_W-1:0] d, input logic p);
    return (^{d, p}) != (ODD_PAR != 0);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PEND_W-1:0] pend_tot_s;
  logic              credit_q, credit_d;
  logic              err_q, err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              ovf_q, ovf_d;

  logic fail_s, pop_s, ovf_beat_s, drop_s, push_s;

  // Beat classification: overflow wins over drop, so a beat that finds the
  // buffer full never earns a credit, even when its parity is bad.
  always_comb begin
    fail_s     = rx_valid && par_fail(rx_data, rx_par);
    pop_s      = (cnt_q != {CNT_W{1'b0}}) && out_ready;
    ovf_beat_s = rx_valid && (cnt_q == FULL_CNT) && !pop_s;
    drop_s     = rx_valid && !ovf_beat_s && fail_s && (DROP_ERR != 0);
    push_s     = rx_valid && !ovf_beat_s && !drop_s;
  end

  // Next-state for FIFO bookkeeping, credit return and error status.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    credit_d  = 1'b0;
    err_d     = fail_s;
    err_cnt_d = err_cnt_q;
    ovf_d     = ovf_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Freed slots are netted against this cycle's outgoing credit so the
    // pulse lands one cycle after the pop or drop that caused it.
    pend_tot_s = pend_q + PEND_W'(pop_s) + PEND_W'(drop_s);
    credit_d   = (pend_tot_s != {PEND_W{1'b0}});
    if (credit_d) begin
      pend_d = pend_tot_s - PEND_W'(1);
    end else begin
      pend_d = pend_tot_s;
    end
    if (pend_d > PEND_MAX) begin
      pend_d = PEND_MAX;
    end else begin
      pend_d = pend_d;
    end

    // A failure in the clearing cycle is still counted.
    if (clr) begin
      err_cnt_d = fail_s ? 16'h0001 : 16'h0000;
    end else if (fail_s && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'h0001;
    end else begin
      err_cnt_d = err_cnt_q;
    end

    if (clr) begin
      ovf_d = ovf_beat_s;
    end else begin
      ovf_d = ovf_q | ovf_beat_s;
    end
  end

  // Control state registers; reset discards buffered beats and pending credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      pend_q    <= {PEND_W{1'b0}};
      credit_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 16'h0000;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      credit_q  <= credit_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Buffer storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign out_valid = (cnt_q != {CNT_W{1'b0}});
  assign out_data  = mem_q[rd_ptr_q];
  assign credit    = credit_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign ovf       = ovf_q;

  pkt_rx_credit_chk #(
    .PEND_W (PEND_W),
    .DEPTH  (DEPTH)
  ) u_chk (
    .clk_i      (clk),
    .rst_i      (rst),
    .pend_tot_i (pend_tot_s),
    .credit_i   (credit_d)
  );

endmodule

// pkt_rx_credit_chk
//   Flags any cycle where the pending-credit count would exceed DEPTH.
// Ports
//   clk_i, rst_i  clock and synchronous reset
//   pend_tot_i    pending credits plus this cycle's increments
//   credit_i      credit being issued this cycle
module pkt_rx_credit_chk #(
  parameter int PEND_W = 4,
  parameter int DEPTH  = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [PEND_W-1:0] pend_tot_i,
  input logic              credit_i
);

  logic [PEND_W-1:0] net_s;

  assign net_s = pend_tot_i - PEND_W'(credit_i);

  a_pend_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    net_s <= PEND_W'(DEPTH));

endmodule

// File: tb/tb_pkt_rx_credit_proc.sv
module tb_pkt_rx_credit_proc;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_par = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr = 1'b0;

  logic          d_credit, d_out_valid, d_err, d_ovf;
  logic [DW-1:0] d_out_data;
  logic [15:0]   d_err_cnt;
  logic          k_credit, k_out_valid, k_err, k_ovf;
  logic [DW-1:0] k_out_data;
  logic [15:0]   k_err_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: index 0 = dropping instance, 1 = keeping instance.
  logic [DW-1:0] q_drop[$];
  logic [DW-1:0] q_keep[$];
  int owed [2];
  int ecnt [2];
  bit movf [2];
  bit merr [2];
  bit mcred[2];

  always #5 clk = ~clk;

  pkt_rx_credit_proc #(.DATA_W(DW), .DEPTH(DEPTH), .DROP_ERR(1), .ODD_PAR(0)) u_drop (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_par(rx_par),
    .credit(d_credit), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_data(d_out_data), .err(d_err), .err_cnt(d_err_cnt), .ovf(d_ovf), .clr(clr));

  pkt_rx_credit_proc #(.DATA_W(DW), .DEPTH(DEPTH), .DROP_ERR(0), .ODD_PAR(0)) u_keep (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_par(rx_par),
    .credit(k_credit), .out_valid(k_out_valid), .out_ready(out_ready),
    .out_data(k_out_data), .err(k_err), .err_cnt(k_err_cnt), .ovf(k_ovf), .clr(clr));

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] q[$];
      bit fail, pop, ob;
      if (i == 0) q = q_drop; else q = q_keep;
      if (rst) begin
        q.delete();
        owed[i] = 0; ecnt[i] = 0; movf[i] = 0; merr[i] = 0; mcred[i] = 0;
      end else begin
        fail = rx_valid && ((^{rx_data, rx_par}) != 1'b0);
        pop  = (q.size() != 0) && out_ready;
        ob   = rx_valid && (q.size() == DEPTH) && !pop;
        if (pop) begin
          void'(q.pop_front());
          owed[i]++;
        end
        if (rx_valid && !ob) begin
          if (fail && i == 0) owed[i]++;
          else q.push_back(rx_data);
        end
        merr[i] = fail;
        if (clr) ecnt[i] = fail ? 1 : 0;
        else if (fail && ecnt[i] < 65535) ecnt[i]++;
        movf[i]  = clr ? ob : (movf[i] | ob);
        mcred[i] = (owed[i] > 0);
        if (owed[i] > 0) owed[i]--;
      end
      if (i == 0) q_drop = q; else q_keep = q;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input bit bad);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_par   = (^d) ^ bad;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    rx_data  = '0;
    rx_par   = 1'b0;
  endtask

  task automatic settle();
    idle();
    clr = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", d_out_valid); end
    checks++; if (d_credit !== 1'b0) begin errors++; $display("FAIL reset_credit got=%0b exp=0", d_credit); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", d_err); end
    checks++; if (d_err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt got=%0h exp=0", d_err_cnt); end
    checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", d_ovf); end
    checks++; if (k_out_valid !== 1'b0) begin errors++; $display("FAIL reset_keep_valid got=%0b exp=0", k_out_valid); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] beats[4];
    beats[0] = 32'hA000_000A; beats[1] = 32'hB000_000B;
    beats[2] = 32'hC000_000C; beats[3] = 32'hD000_000D;
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive_beat(beats[j], 1'b0);
      if (j == 0) begin
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL fill_latency got=%0b exp=0", d_out_valid); end
      end
      tick();
      checks++; if (d_out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid j=%0d got=%0b exp=1", j, d_out_valid); end
      checks++; if (d_credit !== 1'b0) begin errors++; $display("FAIL fill_credit j=%0d got=%0b exp=0", j, d_credit); end
    end
    idle();
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++; if (d_out_data !== beats[j]) begin errors++; $display("FAIL drain_data j=%0d got=%0h exp=%0h", j, d_out_data, beats[j]); end
      checks++; if (k_out_data !== beats[j]) begin errors++; $display("FAIL drain_keep_data j=%0d got=%0h exp=%0h", j, k_out_data, beats[j]); end
      tick();
      checks++; if (d_credit !== 1'b1) begin errors++; $display("FAIL drain_credit j=%0d got=%0b exp=1", j, d_credit); end
    end
    out_ready = 1'b0;
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", d_out_valid); end
    tick();
    checks++; if (d_credit !== 1'b0) begin errors++; $display("FAIL drain_credit_end got=%0b exp=0", d_credit); end
  endtask

  task automatic test_parity();
    logic [DW-1:0] x;
    x = 32'h1234_5678;
    out_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = x ^ 32'h0000_0020;
    rx_par   = ^x;
    tick();
    idle();
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL par_err got=%0b exp=1", d_err); end
    checks++; if (d_err_cnt !== 16'h1) begin errors++; $display("FAIL par_err_cnt got=%0h exp=1", d_err_cnt); end
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL par_dropped got=%0b exp=0", d_out_valid); end
    checks++; if (d_credit !== 1'b1) begin errors++; $display("FAIL par_credit got=%0b exp=1", d_credit); end
    checks++; if (k_err !== 1'b1) begin errors++; $display("FAIL par_keep_err got=%0b exp=1", k_err); end
    checks++; if (k_out_valid !== 1'b1) begin errors++; $display("FAIL par_keep_valid got=%0b exp=1", k_out_valid); end
    checks++; if (k_out_data !== (x ^ 32'h0000_0020)) begin errors++; $display("FAIL par_keep_data got=%0h exp=%0h", k_out_data, x ^ 32'h0000_0020); end
    checks++; if (k_credit !== 1'b0) begin errors++; $display("FAIL par_keep_credit got=%0b exp=0", k_credit); end
    tick();
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL par_err_pulse got=%0b exp=0", d_err); end
    checks++; if (d_credit !== 1'b0) begin errors++; $display("FAIL par_credit_pulse got=%0b exp=0", d_credit); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (k_credit !== 1'b1) begin errors++; $display("FAIL par_keep_pop_credit got=%0b exp=1", k_credit); end
    settle();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_order[4];
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive_beat(32'h5500_0000 + DW'(j), 1'b0);
      tick();
    end
    drive_beat(32'hEEEE_EEEE, 1'b0);
    tick();
    checks++; if (d_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", d_ovf); end
    checks++; if (d_credit !== 1'b0) begin errors++; $display("FAIL ovf_credit got=%0b exp=0", d_credit); end
    checks++; if (d_out_data !== 32'h5500_0000) begin errors++; $display("FAIL ovf_head got=%0h exp=55000000", d_out_data); end
    drive_beat(32'h6666_6666, 1'b0);
    clr = 1'b1;
    tick();
    checks++; if (d_ovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_coincident got=%0b exp=1", d_ovf); end
    idle();
    tick();
    clr = 1'b0;
    checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%0b exp=0", d_ovf); end
    drive_beat(32'hF00D_F00D, 1'b0);
    out_ready = 1'b1;
    tick();
    idle();
    checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL full_pop_ovf got=%0b exp=0", d_ovf); end
    checks++; if (d_credit !== 1'b1) begin errors++; $display("FAIL full_pop_credit got=%0b exp=1", d_credit); end
    exp_order[0] = 32'h5500_0001; exp_order[1] = 32'h5500_0002;
    exp_order[2] = 32'h5500_0003; exp_order[3] = 32'hF00D_F00D;
    for (int j = 0; j < 4; j++) begin
      checks++; if (d_out_data !== exp_order[j]) begin errors++; $display("FAIL full_pop_order j=%0d got=%0h exp=%0h", j, d_out_data, exp_order[j]); end
      tick();
    end
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL full_pop_count got=%0b exp=0", d_out_valid); end
    settle();
  endtask

  task automatic test_drop_pop();
    out_ready = 1'b0;
    drive_beat(32'h0000_ABCD, 1'b0);
    tick();
    drive_beat(32'h0000_1111, 1'b1);
    out_ready = 1'b1;
    tick();
    idle();
    out_ready = 1'b0;
    checks++; if (d_credit !== 1'b1) begin errors++; $display("FAIL dp_credit1 got=%0b exp=1", d_credit); end
    tick();
    checks++; if (d_credit !== 1'b1) begin errors++; $display("FAIL dp_credit2 got=%0b exp=1", d_credit); end
    tick();
    checks++; if (d_credit !== 1'b0) begin errors++; $display("FAIL dp_credit3 got=%0b exp=0", d_credit); end
    settle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive_beat(32'h7700_0000 + DW'(j), 1'b0);
      tick();
    end
    drive_beat(32'h0000_2222, 1'b1);
    out_ready = 1'b1;
    tick();
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%0b exp=0", d_out_valid); end
    checks++; if (d_credit !== 1'b0) begin errors++; $display("FAIL rstmid_credit got=%0b exp=0", d_credit); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%0b exp=0", d_err); end
    checks++; if (d_err_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_err_cnt got=%0h exp=0", d_err_cnt); end
    checks++; if (k_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_keep_valid got=%0b exp=0", k_out_valid); end
    tick();
    checks++; if (d_credit !== 1'b0) begin errors++; $display("FAIL rstmid_credit_lost got=%0b exp=0", d_credit); end
    drive_beat(32'h9999_0001, 1'b0);
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_latency got=%0b exp=0", d_out_valid); end
    tick();
    idle();
    checks++; if (d_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid got=%0b exp=1", d_out_valid); end
    checks++; if (d_out_data !== 32'h9999_0001) begin errors++; $display("FAIL rstmid_new_data got=%0h exp=99990001", d_out_data); end
    settle();
  endtask

  task automatic test_err_sat();
    out_ready = 1'b1;
    for (int j = 0; j < 65535; j++) begin
      drive_beat($urandom, 1'b1);
      tick();
    end
    idle();
    checks++; if (d_err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_preload got=%0h exp=ffff", d_err_cnt); end
    checks++; if (k_err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_keep_preload got=%0h exp=ffff", k_err_cnt); end
    drive_beat(32'hBAD0_0001, 1'b1);
    tick();
    checks++; if (d_err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%0h exp=ffff", d_err_cnt); end
    drive_beat(32'hBAD0_0002, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle();
    checks++; if (d_err_cnt !== 16'h0001) begin errors++; $display("FAIL sat_clr_fail got=%0h exp=1", d_err_cnt); end
    checks++; if (k_err_cnt !== 16'h0001) begin errors++; $display("FAIL sat_keep_clr_fail got=%0h exp=1", k_err_cnt); end
    settle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      checks++; if (d_out_valid !== (q_drop.size() != 0)) begin errors++; $display("FAIL rnd_d_valid n=%0d got=%0b exp=%0b", n, d_out_valid, q_drop.size() != 0); end
      if (q_drop.size() != 0) begin
        checks++; if (d_out_data !== q_drop[0]) begin errors++; $display("FAIL rnd_d_data n=%0d got=%0h exp=%0h", n, d_out_data, q_drop[0]); end
      end
      checks++; if (d_credit !== mcred[0]) begin errors++; $display("FAIL rnd_d_credit n=%0d got=%0b exp=%0b", n, d_credit, mcred[0]); end
      checks++; if (d_err !== merr[0]) begin errors++; $display("FAIL rnd_d_err n=%0d got=%0b exp=%0b", n, d_err, merr[0]); end
      checks++; if (d_err_cnt !== 16'(ecnt[0])) begin errors++; $display("FAIL rnd_d_err_cnt n=%0d got=%0h exp=%0h", n, d_err_cnt, ecnt[0]); end
      checks++; if (d_ovf !== movf[0]) begin errors++; $display("FAIL rnd_d_ovf n=%0d got=%0b exp=%0b", n, d_ovf, movf[0]); end
      checks++; if (k_out_valid !== (q_keep.size() != 0)) begin errors++; $display("FAIL rnd_k_valid n=%0d got=%0b exp=%0b", n, k_out_valid, q_keep.size() != 0); end
      if (q_keep.size() != 0) begin
        checks++; if (k_out_data !== q_keep[0]) begin errors++; $display("FAIL rnd_k_data n=%0d got=%0h exp=%0h", n, k_out_data, q_keep[0]); end
      end
      checks++; if (k_credit !== mcred[1]) begin errors++; $display("FAIL rnd_k_credit n=%0d got=%0b exp=%0b", n, k_credit, mcred[1]); end
      checks++; if (k_err !== merr[1]) begin errors++; $display("FAIL rnd_k_err n=%0d got=%0b exp=%0b", n, k_err, merr[1]); end
      checks++; if (k_err_cnt !== 16'(ecnt[1])) begin errors++; $display("FAIL rnd_k_err_cnt n=%0d got=%0h exp=%0h", n, k_err_cnt, ecnt[1]); end
      checks++; if (k_ovf !== movf[1]) begin errors++; $display("FAIL rnd_k_ovf n=%0d got=%0b exp=%0b", n, k_ovf, movf[1]); end
      if ($urandom_range(0, 99) < 60) drive_beat($urandom, $urandom_range(0, 99) < 20);
      else idle();
      out_ready = ($urandom_range(0, 99) < 50);
      clr       = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    clr = 1'b0;
    settle();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_parity();
    test_overflow();
    test_drop_pop();
    test_reset_mid();
    test_err_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
